// File: rtl/mmio_pkg.sv
// Shared address map and button bit positions for the MMIO button bridge.
package mmio_pkg;

  localparam logic [31:0] ADDR_BTNC = 32'd1000;
  localparam logic [31:0] ADDR_OUT  = 32'd2000;
  localparam logic [31:0] ADDR_BTNL = 32'd3000;
  localparam logic [31:0] ADDR_BTNR = 32'd4000;
  localparam logic [31:0] ADDR_BTNU = 32'd5000;
  localparam logic [31:0] ADDR_BTND = 32'd6000;

  localparam int NUM_BTN = 5;
  localparam int BTN_C   = 0;
  localparam int BTN_L   = 1;
  localparam int BTN_R   = 2;
  localparam int BTN_U   = 3;
  localparam int BTN_D   = 4;

endpackage

// File: rtl/mmio_out_fifo.sv
// Small synchronous FIFO feeding the VGA controller; head word is presented
// combinationally and reads as zero while empty.
module mmio_out_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_button_bridge.sv
// Data-memory MMIO bridge: routes stores to RAM or the VGA FIFO and serves
// sticky button events through a fixed one-cycle load path.
module mmio_button_bridge
  import mmio_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        address_dmem,
  input  logic               wren,
  input  logic [31:0]        data,
  output logic [31:0]        q_dmem,
  input  logic [31:0]        ram_dataOut,
  output logic               ram_wEn,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_pending,
  output logic [31:0]        vga_data,
  output logic               vga_valid,
  input  logic               vga_ready,
  output logic               out_overflow
);

  logic [NUM_BTN-1:0] btn_sel;
  logic [NUM_BTN-1:0] btn_q;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_clr;
  logic               is_out;
  logic               is_btn;
  logic               is_mmio;
  logic               rd_ram;
  logic               rd_bit;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_full;

  always_comb begin
    btn_sel        = '0;
    btn_sel[BTN_C] = (address_dmem == ADDR_BTNC);
    btn_sel[BTN_L] = (address_dmem == ADDR_BTNL);
    btn_sel[BTN_R] = (address_dmem == ADDR_BTNR);
    btn_sel[BTN_U] = (address_dmem == ADDR_BTNU);
    btn_sel[BTN_D] = (address_dmem == ADDR_BTND);
  end

  assign is_out   = (address_dmem == ADDR_OUT);
  assign is_btn   = |btn_sel;
  assign is_mmio  = is_out | is_btn;
  assign ram_wEn  = wren & ~is_mmio;
  assign btn_rise = btn_in & ~btn_q;
  assign btn_clr  = wren ? '0 : btn_sel;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_q        <= '0;
      btn_pending  <= '0;
      rd_ram       <= 1'b0;
      rd_bit       <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      btn_q        <= btn_in;
      // A new press wins over a clearing read in the same cycle.
      btn_pending  <= (btn_pending & ~btn_clr) | btn_rise;
      rd_ram       <= ~is_mmio;
      rd_bit       <= |(btn_pending & btn_sel);
      if (push & fifo_full & ~pop) out_overflow <= 1'b1;
    end
  end

  assign q_dmem = rd_ram ? ram_dataOut : {31'b0, rd_bit};

  assign push      = wren & is_out;
  assign pop       = vga_valid & vga_ready;
  assign vga_valid = ~fifo_empty;

  mmio_out_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_out_fifo (
    .clock(clock),
    .reset(reset),
    .push (push),
    .din  (data),
    .pop  (pop),
    .dout (vga_data),
    .empty(fifo_empty),
    .full (fifo_full)
  );

endmodule
